control_d_writeback: RTL and testbench
======================================

// Module: control_d_writeback
// PURPOSE
//  Write-back end of the operand path. Accepts the per-lane result stream leaving the 8-lane
//  PE array, one cycle skewed per lane (lane i one cycle after lane i-1). Packs results per
//  datatype, buffers against SRAM back-pressure, generates per-lane word addresses and writes D to SRAM.
//  Signals completion once every lane has written its expected word count.
// PARAMETERS
//  LANES       8   number of result lanes / SRAM write ports
//  FIFO_DEPTH  4   per-lane packed-word buffer depth (power of 2, >=2)
// PORTS
//  clk         in   1          clock
//  rst         in   1          synchronous reset, active-low (rst==0 resets)
//  start       in   1          1-cycle pulse; latches cfg below when IDLE
//  base_addr   in   32         byte address of D[0][0]; [1:0] ignored
//  row_stride  in   32         byte stride between rows; [1:0] ignored
//  rows        in   8          results expected per lane
//  addrtype    in   addrgen_t  params::addrgen_t; only .datatype used
//  en_in       in   LANES      per-lane result valid (skewed)
//  data_in     in   LANES*32   per-lane result; FP16 uses [15:0]
//  wr_ready    in   LANES      SRAM port accepts write this cycle
//  we          out  LANES      write valid
//  wraddr      out  LANES*30   word address
//  wrdata      out  LANES*32   write data
//  wstrb       out  LANES*4    byte strobes
//  busy        out  1          high in RUN and DONE
//  done        out  1          1-cycle completion pulse
//  ovf_err     out  1          sticky overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FSM=IDLE; we, wstrb, busy, done, ovf_err = 0; wraddr, wrdata = 0; FIFOs, counters, pack regs cleared.
//  - FSM IDLE->RUN on start (cfg latched). RUN->DONE when every lane's write count == target.
//    DONE->IDLE next cycle with done=1 for that single cycle. start outside IDLE ignored.
//  - rows==0: start -> DONE the next cycle -> done pulse; no writes.
//  - en_in outside RUN is dropped silently.
//  - Target per lane: INT8/INT4/default = rows words; FP16 = ceil(rows/2) words.
//  - Packing: 32-bit modes: each result is one word, wstrb=4'hF. FP16: 1st result -> low half
//    (held); 2nd -> high half, word pushed, wstrb=4'hF. After the final odd result the word is
//    pushed at once with upper 16 bits = 0, wstrb=4'h3.
//  - Push into lane FIFO on the cycle the word completes. we/wraddr/wrdata/wstrb are registered
//    from the FIFO head: earliest we is 1 cycle after the completing en_in.
//  - Handshake: valid/ready. we, wraddr, wrdata and wstrb hold stable while we && !wr_ready.
//    A transfer occurs when we && wr_ready. Pop and next-head load happen the same cycle, so
//    back-to-back writes run at one per cycle.
//  - Address: lane i, k-th word = base_addr[31:2] + i + k*row_stride[31:2], built by an
//    incremental adder per lane. Wraps mod 2^30.
//  - FIFO full && push && no pop this cycle: the word is dropped and still counted, so done is
//    still reached. Full && push && pop: accepted.
//  - rst low mid-RUN: immediate return to IDLE, no done, in-flight words discarded.
// CONFIGURATION
//  CTRL_D_OVF_CHECK_EN defined:
//    - ovf_err set on any dropped word (FIFO overflow); cleared only by rst.
//    - simulation assertion fires on drop.
//  Undefined:
//    - ovf_err tied 0; no drop detection logic.
//    - drop behaviour itself unchanged.
// STRUCTURE
//  params package: add WB_LANES=8 and typedef wb_state_t {WB_IDLE, WB_RUN, WB_DONE}.
//    Reuse the existing addrgen_t / datatype enum.
//  Sub-module control_d_wb_lane (x LANES via generate):
//    - FP16 pack register
//    - FIFO
//    - address adder
//    - word counter
//    - lane_done output
//  Top-level: FSM, cfg latch, AND of lane_done.
// TESTING
//  1 INT8, rows=4, base=0x100, stride=0x20, wr_ready=all 1, skewed beats
//    -> lane0 wraddr 0x40,0x48,0x50,0x58; lane7 0x47..0x5F
//    -> wstrb=F; one done pulse after lane7's last write.
//  2 FP16, rows=3, lane0 data 0x1111,0x2222,0x3333
//    -> writes 0x22221111/strobe F then 0x00003333/strobe 3; done after 2 words per lane.
//  3 INT4, rows=6, wr_ready lane2 low 3 cycles mid-stream
//    -> we/data held stable; all 6 words in order; ovf_err=0.
//  4 rows=8, wr_ready all low for 6 beats, FIFO_DEPTH=4
//    -> words 5,6 dropped; ovf_err=1 with macro, 0 without; done still pulses.
//  5 rows=0 start -> done=1 exactly the following+1 cycle, no we; start during RUN ignored.
//  6 rst=0 after 2 of 4 rows -> all outputs 0 next cycle, no done; fresh start completes normally.

Source files
------------

// File: rtl/control_d_writeback_pkg.sv
// Shared types for the D write-back path: datatype/addrgen config, FSM states, buffered word.
package control_d_writeback_pkg;

    localparam int WB_LANES = 8;

    typedef enum logic [1:0] {
        DT_INT8 = 2'd0,
        DT_INT4 = 2'd1,
        DT_FP16 = 2'd2,
        DT_FP32 = 2'd3
    } datatype_t;

    typedef struct packed {
        datatype_t   datatype;
        logic        transpose;
        logic [4:0]  tile;
    } addrgen_t;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_RUN  = 2'd1,
        WB_DONE = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wb_word_t;

    // Words each lane must retire: FP16 packs two results per word.
    function automatic logic [7:0] wb_target(input datatype_t dt, input logic [7:0] rows);
        logic [8:0] half_up;
        half_up = {1'b0, rows} + 9'd1;
        return (dt == DT_FP16) ? half_up[8:1] : rows;
    endfunction

endpackage

// File: rtl/control_d_wb_lane.sv
// One write-back lane: FP16 packing, word FIFO whose head drives the SRAM port, address adder,
// retired-word counter. First we one cycle after the completing result; head holds while !wr_ready.
module control_d_wb_lane
    import control_d_writeback_pkg::*;
#(
    parameter int LANE_IDX   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        run_i,
    input  logic        fp16_i,
    input  logic [29:0] base_w_i,
    input  logic [29:0] stride_w_i,
    input  logic [7:0]  rows_i,
    input  logic [7:0]  target_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    input  logic        wr_ready_i,
    output logic        we_o,
    output logic [29:0] wraddr_o,
    output logic [31:0] wrdata_o,
    output logic [3:0]  wstrb_o,
    output logic        lane_done_o,
    output logic        drop_o
);

    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    wb_word_t        mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     cnt_q, cnt_d;
    logic [7:0]      res_cnt_q;
    logic [7:0]      wr_cnt_q;
    logic [29:0]     off_q;
    logic            half_vld_q;
    logic [15:0]     half_q;

    logic            beat, last_beat, push, push_ok, pop, full;
    wb_word_t        push_word, head;

    always_comb begin
        beat           = en_i && run_i && (res_cnt_q != rows_i);
        last_beat      = (res_cnt_q + 8'd1) == rows_i;
        push           = 1'b0;
        push_word      = '0;
        push_word.addr = base_w_i + 30'(LANE_IDX) + off_q;
        if (beat) begin
            if (!fp16_i) begin
                push           = 1'b1;
                push_word.data = data_i;
                push_word.strb = 4'hF;
            end else if (half_vld_q) begin
                push           = 1'b1;
                push_word.data = {data_i[15:0], half_q};
                push_word.strb = 4'hF;
            end else if (last_beat) begin
                // Odd tail: ship the lone low half immediately.
                push           = 1'b1;
                push_word.data = {16'h0000, data_i[15:0]};
                push_word.strb = 4'h3;
            end
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign full    = (cnt_q == DEPTH_C);
    assign we_o    = (cnt_q != '0);
    assign pop     = we_o && wr_ready_i;
    // A slot freed by this cycle's pop makes room even when full.
    assign drop_o  = push && full && !pop;
    assign push_ok = push && !drop_o;

    assign wraddr_o    = head.addr;
    assign wrdata_o    = head.data;
    assign wstrb_o     = head.strb;
    assign lane_done_o = (wr_cnt_q == target_i);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            res_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            off_q      <= '0;
            half_vld_q <= 1'b0;
            half_q     <= '0;
        end else begin
            if (beat) begin
                res_cnt_q <= res_cnt_q + 8'd1;
                if (fp16_i) begin
                    if (half_vld_q) begin
                        half_vld_q <= 1'b0;
                    end else if (!last_beat) begin
                        half_vld_q <= 1'b1;
                        half_q     <= data_i[15:0];
                    end
                end
            end
            // Dropped words still consume their address slot.
            if (push) begin
                off_q <= off_q + stride_w_i;
            end
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
            if (pop || drop_o) begin
                wr_cnt_q <= wr_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/control_d_writeback.sv
// D write-back top: FSM IDLE/RUN/DONE, cfg latch, per-lane pack/FIFO/address; done when all lanes retire.
// Build option CTRL_D_OVF_CHECK_EN adds a sticky ovf_err on FIFO drops plus a drop assertion.
module control_d_writeback
    import control_d_writeback_pkg::*;
#(
    parameter int LANES      = WB_LANES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         base_addr,
    input  logic [31:0]         row_stride,
    input  logic [7:0]          rows,
    input  addrgen_t            addrtype,
    input  logic [LANES-1:0]    en_in,
    input  logic [LANES*32-1:0] data_in,
    input  logic [LANES-1:0]    wr_ready,
    output logic [LANES-1:0]    we,
    output logic [LANES*30-1:0] wraddr,
    output logic [LANES*32-1:0] wrdata,
    output logic [LANES*4-1:0]  wstrb,
    output logic                busy,
    output logic                done,
    output logic                ovf_err
);

    wb_state_t        state_q, state_d;
    logic [29:0]      base_w_q, stride_w_q;
    logic [7:0]       rows_q, target_q;
    logic             fp16_q;
    logic             accept, run, all_done;
    logic [LANES-1:0] lane_done, lane_drop;
    logic             cfg_unused;

    assign cfg_unused = ^{base_addr[1:0], row_stride[1:0], addrtype.transpose, addrtype.tile};

    assign accept   = start && (state_q == WB_IDLE);
    assign run      = (state_q == WB_RUN);
    assign all_done = &lane_done;
    assign busy     = (state_q != WB_IDLE);
    assign done     = (state_q == WB_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (start)    state_d = WB_RUN;
            WB_RUN:  if (all_done) state_d = WB_DONE;
            WB_DONE:               state_d = WB_IDLE;
            default:               state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= WB_IDLE;
            base_w_q   <= '0;
            stride_w_q <= '0;
            rows_q     <= '0;
            target_q   <= '0;
            fp16_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_w_q   <= base_addr[31:2];
                stride_w_q <= row_stride[31:2];
                rows_q     <= rows;
                target_q   <= wb_target(addrtype.datatype, rows);
                fp16_q     <= (addrtype.datatype == DT_FP16);
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        control_d_wb_lane #(
            .LANE_IDX   (g),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .clr_i       (accept),
            .run_i       (run),
            .fp16_i      (fp16_q),
            .base_w_i    (base_w_q),
            .stride_w_i  (stride_w_q),
            .rows_i      (rows_q),
            .target_i    (target_q),
            .en_i        (en_in[g]),
            .data_i      (data_in[g*32 +: 32]),
            .wr_ready_i  (wr_ready[g]),
            .we_o        (we[g]),
            .wraddr_o    (wraddr[g*30 +: 30]),
            .wrdata_o    (wrdata[g*32 +: 32]),
            .wstrb_o     (wstrb[g*4 +: 4]),
            .lane_done_o (lane_done[g]),
            .drop_o      (lane_drop[g])
        );
    end

`ifdef CTRL_D_OVF_CHECK_EN
    logic ovf_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_err_q <= 1'b0;
        end else if (|lane_drop) begin
            ovf_err_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_err_q;

    a_no_drop: assert property (@(posedge clk) disable iff (!rst) !(|lane_drop))
        else $error("write-back lane FIFO overflow: word dropped");
`else
    logic drop_unused;
    assign drop_unused = |lane_drop;
    assign ovf_err     = 1'b0;
`endif

endmodule

// File: tb/tb_control_d_writeback.sv
// Directed table-driven bench for control_d_writeback with a write-capturing monitor.
module tb_control_d_writeback;
    import control_d_writeback_pkg::*;

    localparam int L = 8;
`ifdef CTRL_D_OVF_CHECK_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start;
    logic [31:0]     base_addr, row_stride;
    logic [7:0]      rows;
    addrgen_t        addrtype;
    logic [L-1:0]    en_in, wr_ready;
    logic [L*32-1:0] data_in;
    logic [L-1:0]    we;
    logic [L*30-1:0] wraddr;
    logic [L*32-1:0] wrdata;
    logic [L*4-1:0]  wstrb;
    logic            busy, done, ovf_err;

    control_d_writeback #(.LANES(L), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_stride(row_stride),
        .rows(rows), .addrtype(addrtype), .en_in(en_in), .data_in(data_in), .wr_ready(wr_ready),
        .we(we), .wraddr(wraddr), .wrdata(wrdata), .wstrb(wstrb),
        .busy(busy), .done(done), .ovf_err(ovf_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        datatype_t   dt;
        int          rows;
        logic [31:0] base;
        logic [31:0] stride;
        logic [7:0]  mask;
        int          st;
        int          len;
        int          drop_lo;
        int          drop_n;
        logic        exp_ovf;
        int          restart;
    } case_t;

    // Write monitor: every accepted write is captured as {addr, data, strb}.
    logic [65:0] wq [L][$];
    int          tcyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          we_cnt = 0;
    int          last_wr [L];
    logic [L-1:0] p_stall = '0;
    logic [65:0] p_word [L];

    always @(posedge clk) tcyc <= tcyc + 1;

    always @(negedge clk) begin
        logic [65:0] w;
        if (done) begin
            done_cnt++;
            done_cyc = tcyc;
        end
        for (int i = 0; i < L; i++) begin
            w = {wraddr[i*30 +: 30], wrdata[i*32 +: 32], wstrb[i*4 +: 4]};
            if (rst && p_stall[i]) begin
                chk($sformatf("hold_we_l%0d", i), {65'b0, we[i]}, 66'd1);
                chk($sformatf("hold_word_l%0d", i), w, p_word[i]);
            end
            if (we[i] && wr_ready[i]) begin
                wq[i].push_back(w);
                last_wr[i] = tcyc;
                we_cnt++;
            end
            p_stall[i] = rst && we[i] && !wr_ready[i];
            p_word[i]  = w;
        end
    end

    function automatic logic [31:0] res(input int i, input int k);
        return {4'(i), 4'hA, 8'(k), 16'h1111 * 16'(k + 1)};
    endfunction

    function automatic logic [65:0] exp_word(input case_t tc, input int i, input int w);
        logic [29:0] a;
        logic [31:0] d, r0, r1;
        logic [3:0]  s;
        a = tc.base[31:2] + 30'(i) + 30'(w) * tc.stride[31:2];
        if (tc.dt == DT_FP16) begin
            r0 = res(i, 2*w);
            if (2*w + 1 < tc.rows) begin
                r1 = res(i, 2*w + 1);
                d  = {r1[15:0], r0[15:0]};
                s  = 4'hF;
            end else begin
                d = {16'h0000, r0[15:0]};
                s = 4'h3;
            end
        end else begin
            d = res(i, w);
            s = 4'hF;
        end
        return {a, d, s};
    endfunction

    task automatic run_job(input case_t tc);
        int c, cool;
        for (int i = 0; i < L; i++) begin
            wq[i].delete();
            last_wr[i] = -1;
        end
        done_cnt   = 0;
        done_cyc   = -1;
        base_addr  = tc.base;
        row_stride = tc.stride;
        rows       = 8'(tc.rows);
        addrtype   = '0;
        addrtype.datatype = tc.dt;
        start = 1'b1;
        @(posedge clk); #1;
        c = 0;
        cool = 0;
        while (c < 300 && cool < 4) begin
            start = 1'b0;
            rows  = 8'(tc.rows);
            if (c == tc.restart) begin
                start = 1'b1;
                rows  = 8'(tc.rows + 3);
            end
            for (int i = 0; i < L; i++) begin
                en_in[i] = (c >= i) && (c < i + tc.rows);
                data_in[i*32 +: 32] = en_in[i] ? res(i, c - i) : 32'hDEADBEEF;
                wr_ready[i] = !(tc.mask[i] && c >= i + tc.st && c < i + tc.st + tc.len);
            end
            @(posedge clk); #1;
            c++;
            if (done_cnt > 0) cool++;
        end
        start    = 1'b0;
        en_in    = '0;
        wr_ready = '1;
    endtask

    task automatic check_case(input int t, input case_t tc);
        int nw, j;
        logic [65:0] got;
        nw = (tc.dt == DT_FP16) ? (tc.rows + 1) / 2 : tc.rows;
        chk($sformatf("c%0d_done_pulses", t), 66'(done_cnt), 66'd1);
        chk($sformatf("c%0d_ovf_err", t), {65'b0, ovf_err}, {65'b0, tc.exp_ovf});
        chk($sformatf("c%0d_busy_after", t), {65'b0, busy}, 66'd0);
        chk($sformatf("c%0d_done_after_l7", t), {65'b0, (done_cyc > last_wr[L-1])}, 66'd1);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("c%0d_l%0d_count", t, i), 66'(wq[i].size()), 66'(nw - tc.drop_n));
            j = 0;
            for (int w = 0; w < nw; w++) begin
                if (w >= tc.drop_lo && w < tc.drop_lo + tc.drop_n) continue;
                got = (j < wq[i].size()) ? wq[i][j] : '0;
                chk($sformatf("c%0d_l%0d_w%0d", t, i, w), got, exp_word(tc, i, w));
                j++;
            end
        end
    endtask

    case_t cases [5];

    initial begin
        cases[0] = '{DT_INT8, 4, 32'h100,  32'h20,  8'h00, 0, 0, 0, 0, 1'b0, -1};
        cases[1] = '{DT_FP16, 3, 32'h200,  32'h40,  8'h00, 0, 0, 0, 0, 1'b0, -1};
        cases[2] = '{DT_INT4, 6, 32'h1000, 32'h10,  8'h04, 3, 3, 0, 0, 1'b0, -1};
        cases[3] = '{DT_INT8, 2, 32'h40,   32'h8,   8'h00, 0, 0, 0, 0, 1'b0, 1};
        cases[4] = '{DT_INT8, 8, 32'h0,    32'h100, 8'hFF, 0, 6, 4, 2, OVF_EXP, -1};

        rst = 1'b0; start = 1'b0; base_addr = '0; row_stride = '0; rows = '0;
        addrtype = '0; en_in = '0; data_in = '0; wr_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 66'(we), 66'd0);
        chk("rst_wraddr", 66'(wraddr[29:0]), 66'd0);
        chk("rst_wrdata", 66'(wrdata[31:0]), 66'd0);
        chk("rst_wstrb", 66'(wstrb), 66'd0);
        chk("rst_busy_done_ovf", {63'b0, busy, done, ovf_err}, 66'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            run_job(cases[t]);
            check_case(t, cases[t]);
            if (t == 0) begin
                chk("c0_l0_addr0", 66'(wq[0][0][65:36]), 66'h40);
                chk("c0_l0_addr1", 66'(wq[0][1][65:36]), 66'h48);
                chk("c0_l0_addr2", 66'(wq[0][2][65:36]), 66'h50);
                chk("c0_l0_addr3", 66'(wq[0][3][65:36]), 66'h58);
                chk("c0_l7_addr0", 66'(wq[7][0][65:36]), 66'h47);
                chk("c0_l7_addr3", 66'(wq[7][3][65:36]), 66'h5F);
            end
            if (t == 1) begin
                chk("c1_l0_word0", 66'(wq[0][0][35:0]), {30'b0, 32'h22221111, 4'hF});
                chk("c1_l0_word1", 66'(wq[0][1][35:0]), {30'b0, 32'h00003333, 4'h3});
            end
        end

        // rows == 0: done two cycles after the start cycle, no writes.
        we_cnt = 0; done_cnt = 0;
        rows = 8'd0; addrtype = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("z_busy_run", {65'b0, busy}, 66'd1);
        chk("z_done_early", {65'b0, done}, 66'd0);
        @(posedge clk); #1;
        chk("z_done_pulse", {65'b0, done}, 66'd1);
        @(posedge clk); #1;
        chk("z_done_clear", {64'b0, done, busy}, 66'd0);
        chk("z_no_writes", 66'(we_cnt), 66'd0);

        // Reset in the middle of a 4-row INT8 job.
        done_cnt = 0;
        base_addr = 32'h100; row_stride = 32'h20; rows = 8'd4; addrtype = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < L; i++) begin
                en_in[i] = (c >= i) && (c < i + 4);
                data_in[i*32 +: 32] = res(i, c - i);
            end
            if (c == 2) rst = 1'b0;
            @(posedge clk); #1;
        end
        en_in = '0;
        chk("mr_we", 66'(we), 66'd0);
        chk("mr_wraddr", 66'(wraddr), 66'd0);
        chk("mr_wrdata", 66'(wrdata[63:0]), 66'd0);
        chk("mr_wstrb", 66'(wstrb), 66'd0);
        chk("mr_flags", {63'b0, busy, done, ovf_err}, 66'd0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mr_no_done", 66'(done_cnt), 66'd0);
        run_job(cases[0]);
        check_case(5, cases[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
